mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
- Multi-cycle integer multiply/divide execution unit in the Execute stage of the pipelined ARM core.
- Drives M_BusyE, which the hazard logic uses to stall F/D/E and flush M.
- Accepts a start request from the Execute stage and runs a WIDTH-iteration shift-add multiply or restoring divide.
- Deasserts Busy for exactly one cycle when the results are valid, so the stalled instruction can advance.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- Start  input  1  request for a multi-cycle op; held high by the pipeline while the instruction sits in E
- MCycleOp  input  1  0 = multiply, 1 = divide
- Operand1  input  WIDTH  multiplicand / dividend
- Operand2  input  WIDTH  multiplier / divisor
- Result1  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient
- Result2  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder
- Busy  output  1  high while the op is in progress; feeds M_BusyE
- Signed  input  1  present only with MCYCLE_SIGNED_EN; 1 = two's-complement operation

Behaviour:
- Reset and clocking: one clock, CLK. RESET is synchronous and active-high; it is sampled only on the rising edge of CLK.
- Reset values (any cycle, including mid-operation):
  - state = IDLE, iteration count = 0.
  - Result1 = 0, Result2 = 0, internal shift registers = 0.
  - Busy is forced to 0 in any cycle where RESET is high.
  - The first cycle after reset is IDLE.
- FSM states:
  - IDLE: Busy = Start, combinational, so the stall takes effect in the same cycle Start rises.
    - If Start = 1: latch Operand1, Operand2, MCycleOp (and Signed); clear count; go to COMPUTE.
    - Else stay in IDLE.
  - COMPUTE: Busy = 1. One iteration per cycle; count increments from 0 to WIDTH-1.
    - When count = WIDTH-1: register Result1/Result2 at that edge and go to DONE.
    - Start, Operand and MCycleOp changes are ignored throughout COMPUTE.
  - DONE: Busy = 0 for exactly one cycle. The pipeline advances the instruction in this cycle.
    - Go to IDLE unconditionally, regardless of Start.
    - This prevents re-triggering on the same held Start.
- Latency: Start sampled in IDLE at cycle 0.
  - Busy is high for cycles 0..WIDTH (WIDTH+1 cycles; 33 for WIDTH=32).
  - DONE is at cycle WIDTH+1; Result1/Result2 are valid from DONE onward.
- Result hold: Result1/Result2 hold their values until the next op completes or until reset.
- Back-to-back: a new Start in the IDLE cycle after DONE begins a new op immediately.
  - Minimum issue interval is WIDTH+2 cycles.
- Multiply: unsigned shift-add over WIDTH iterations; full 2*WIDTH-bit product.
- Divide: restoring division, one quotient bit per iteration.
  - Divisor = 0: quotient = all ones, remainder = dividend. No exception and no extra cycles.
- Width rules: internal accumulator is 2*WIDTH bits; no truncation before the final split into Result1/Result2.

Optional Feature:
- Macro: MCYCLE_SIGNED_EN.
- Defined:
  - The Signed port exists.
  - For a signed op, operands are converted to magnitudes when latched in IDLE.
  - The unsigned core runs unchanged; result signs are fixed up in the final COMPUTE edge, so latency is unchanged.
  - Product sign = XOR of operand signs.
  - Division truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero returns quotient = all ones and remainder = dividend, regardless of Signed.
- Not defined:
  - No Signed port; all ops are unsigned.

Test Plan:
- Multiply 7 × 6, Start held → Busy high 33 cycles from the Start cycle, then low 1 cycle; Result1 = 0x0000002A, Result2 = 0x00000000.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → Result1 = 0x00000001, Result2 = 0xFFFFFFFE.
- Divide 100 / 7 → Result1 = 0x0000000E, Result2 = 0x00000002; a divide of 0x1234 by 0 → Result1 = 0xFFFFFFFF, Result2 = 0x00001234.
- Start held through DONE, then deasserted → no second op; Busy stays 0 in IDLE. Two ops issued back-to-back (Start re-raised the cycle after DONE) → second begins immediately with correct result.
- RESET pulsed at COMPUTE count 10 → next cycle IDLE, Busy = 0, Result1 = Result2 = 0; a subsequent 3 × 5 yields Result1 = 0x0000000F.
- With MCYCLE_SIGNED_EN, Signed = 1:
  - -7 × 3 → Result1 = 0xFFFFFFEB, Result2 = 0xFFFFFFFF.
  - -7 / 2 → Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF.

Source files
------------

// File: rtl/mcycle_unit.sv
// Purpose: multi-cycle multiply (shift-add) / divide (restoring) unit for the Execute stage.
// Latency: Busy high WIDTH+1 cycles from the Start cycle, results valid in the following DONE cycle.
// Backpressure: Busy stalls F/D/E; it drops for exactly one DONE cycle so the instruction can advance.
// Optional: define MCYCLE_SIGNED_EN to add the Signed port and two's-complement operation.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic             MCycleOp,
`ifdef MCYCLE_SIGNED_EN
   input  logic             Signed,
`endif
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_count;
   logic               r_op;        // 0 = multiply, 1 = divide
   logic [WIDTH-1:0]   r_opb;       // multiplicand (mul) or divisor (div), as a magnitude
   logic [2*WIDTH-1:0] r_acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic               r_neg_a;
   logic               r_neg_b;
   logic [WIDTH-1:0]   r_result1;
   logic [WIDTH-1:0]   r_result2;

   logic               w_signed;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH-1:0]   w_diff;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_div0;
   logic [WIDTH-1:0]   w_fin1;
   logic [WIDTH-1:0]   w_fin2;

`ifdef MCYCLE_SIGNED_EN
   assign w_signed = Signed;
`else
   assign w_signed = 1'b0;
`endif

   // Signed operands are reduced to magnitudes at latch time so the core stays unsigned.
   // The most negative value maps onto itself, which is its correct unsigned magnitude.
   always_comb begin
      w_neg_a = w_signed & Operand1[WIDTH-1];
      w_neg_b = w_signed & Operand2[WIDTH-1];
      w_mag_a = w_neg_a ? -Operand1 : Operand1;
      w_mag_b = w_neg_b ? -Operand2 : Operand2;
   end

   // One iteration of each algorithm; the opcode picks which one updates the accumulator.
   always_comb begin
      // Shift-add: conditionally add the multiplicand to the high half, then shift right
      // with the carry so the full 2*WIDTH product builds up without truncation.
      w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
      w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
      // Restoring divide: bring in the next dividend bit, subtract when it fits.
      // The remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
      // and any successful difference fits back in WIDTH bits. A zero divisor always
      // "fits", yielding an all-ones quotient and the dividend as remainder.
      w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_ge       = (w_rem_sh >= {1'b0, r_opb});
      w_diff     = w_rem_sh[WIDTH-1:0] - r_opb;
      w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                        : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      w_next     = r_op ? w_div_next : w_mul_next;
   end

   // Sign fix-up on the value produced by the final iteration, so latency is unaffected.
   always_comb begin
      w_prod = (r_neg_a ^ r_neg_b) ? -w_next : w_next;
      w_quo  = w_next[WIDTH-1:0];
      w_rem  = w_next[2*WIDTH-1:WIDTH];
      w_div0 = (r_opb == {WIDTH{1'b0}});
      if (r_op) begin
         // Divide by zero keeps the all-ones quotient regardless of operand signs.
         w_fin1 = w_div0 ? {WIDTH{1'b1}} : ((r_neg_a ^ r_neg_b) ? -w_quo : w_quo);
         w_fin2 = r_neg_a ? -w_rem : w_rem;
      end else begin
         w_fin1 = w_prod[WIDTH-1:0];
         w_fin2 = w_prod[2*WIDTH-1:WIDTH];
      end
   end

   // Busy is combinational so the stall lands in the same cycle Start rises.
   always_comb begin
      Busy = 1'b0;
      if (!RESET) begin
         case (r_state)
            S_IDLE:    Busy = Start;
            S_COMPUTE: Busy = 1'b1;
            default:   Busy = 1'b0;
         endcase
      end
   end

   // Control FSM and datapath registers; DONE always returns to IDLE so a held Start cannot retrigger.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_op      <= 1'b0;
         r_opb     <= '0;
         r_acc     <= '0;
         r_neg_a   <= 1'b0;
         r_neg_b   <= 1'b0;
         r_result1 <= '0;
         r_result2 <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_op    <= MCycleOp;
                  r_opb   <= MCycleOp ? w_mag_b : w_mag_a;
                  r_acc   <= {{WIDTH{1'b0}}, (MCycleOp ? w_mag_a : w_mag_b)};
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  r_count <= '0;
                  r_state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               r_acc   <= w_next;
               r_count <= r_count + CW'(1);
               if (r_count == LAST) begin
                  r_result1 <= w_fin1;
                  r_result2 <= w_fin2;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Result1 = r_result1;
   assign Result2 = r_result2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit (WIDTH = 32) against a timeline/arithmetic model.
// Directed cases from the feature list, then randomized back-to-back and gapped ops.
// Signed cases are only exercised when MCYCLE_SIGNED_EN is defined.
module tb_mcycle_unit;

   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          Start;
   logic          MCycleOp;
   logic          sgn;
   logic [W-1:0]  Operand1;
   logic [W-1:0]  Operand2;
   logic [W-1:0]  Result1;
   logic [W-1:0]  Result2;
   logic          Busy;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model state: whether an op is in flight, how many cycles since its Start cycle,
   // the pending result and the currently visible result.
   bit            m_active = 1'b0;
   int            m_k      = 0;
   logic [W-1:0]  m_p1, m_p2;
   logic [W-1:0]  m_r1 = '0;
   logic [W-1:0]  m_r2 = '0;

   mcycle_unit #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Start    (Start),
      .MCycleOp (MCycleOp),
`ifdef MCYCLE_SIGNED_EN
      .Signed   (sgn),
`endif
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {Result2, Result1}.
   function automatic logic [63:0] ref_op(input logic op, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         if (s) res = sa * sb;
         else   res = {32'b0, a} * {32'b0, b};
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
         res = {r[31:0], q[31:0]};
      end else begin
         res = {a % b, a / b};
      end
      return res;
   endfunction

   // Model timeline: Start in an idle cycle is cycle 0; results appear at cycle W+1.
   always @(posedge CLK) begin
      if (RESET) begin
         m_active = 1'b0;
         m_k      = 0;
         m_r1     = '0;
         m_r2     = '0;
      end else if (!m_active) begin
         if (Start) begin
            m_active = 1'b1;
            m_k      = 1;
            {m_p2, m_p1} = ref_op(MCycleOp, Operand1, Operand2, sgn);
         end
      end else if (m_k == W) begin
         m_r1 = m_p1;
         m_r2 = m_p2;
         m_k  = W + 1;
      end else if (m_k == W + 1) begin
         m_active = 1'b0;
      end else begin
         m_k++;
      end
   end

   // Every-cycle comparison of Busy and results against the model.
   always @(negedge CLK) begin
      logic exp_busy;
      if (chk_en) begin
         if (RESET)          exp_busy = 1'b0;
         else if (!m_active) exp_busy = Start;
         else                exp_busy = (m_k <= W);
         chk("busy", {63'b0, Busy}, {63'b0, exp_busy});
         chk("result1", {32'b0, Result1}, {32'b0, m_r1});
         chk("result2", {32'b0, Result2}, {32'b0, m_r2});
      end
   end

   // Issue one op starting in the next cycle and count its Busy-high cycles.
   // Returns at the falling edge of the DONE cycle with Start still as left.
   task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit scramble);
      int n;
      bit done;
      @(posedge CLK);
      #1;
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      sgn      = s;
      Start    = 1'b1;
      n        = 0;
      done     = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge CLK);
         if (!Busy) begin
            done = 1'b1;
         end else begin
            n++;
            @(posedge CLK);
            #1;
            if (scramble) begin
               Operand1 = $urandom;
               Operand2 = $urandom;
               MCycleOp = 1'($urandom);
               Start    = 1'($urandom);
            end
         end
      end
      chk("busy_len", 64'(n), 64'(W + 1));
   endtask

   task automatic go_idle(input int cycles);
      @(posedge CLK);
      #1;
      Start = 1'b0;
      repeat (cycles) @(posedge CLK);
   endtask

   initial begin
      logic        r_op_t, r_s_t;
      logic [31:0] ra, rb;
      int          gap;
      RESET    = 1'b1;
      Start    = 1'b0;
      MCycleOp = 1'b0;
      sgn      = 1'b0;
      Operand1 = '0;
      Operand2 = '0;
      @(posedge CLK);
      #1 chk_en = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("reset_busy", {63'b0, Busy}, 64'd0);
      chk("reset_r1", {32'b0, Result1}, 64'd0);
      chk("reset_r2", {32'b0, Result2}, 64'd0);

      // 7 x 6 with Start held through DONE, then dropped: no second op.
      do_op(1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
      chk("mul7x6_r1", {32'b0, Result1}, 64'h2A);
      chk("mul7x6_r2", {32'b0, Result2}, 64'h0);
      go_idle(0);
      @(negedge CLK);
      chk("idle_after_done", {63'b0, Busy}, 64'd0);
      go_idle(2);

      // Back-to-back chain: max multiply, divide (inputs scrambled mid-op), divide by zero.
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("mulmax_r1", {32'b0, Result1}, 64'h1);
      chk("mulmax_r2", {32'b0, Result2}, 64'hFFFF_FFFE);
      do_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b1);
      chk("div100_7_r1", {32'b0, Result1}, 64'hE);
      chk("div100_7_r2", {32'b0, Result2}, 64'h2);
      do_op(1'b1, 32'h1234, 32'd0, 1'b0, 1'b0);
      chk("div0_r1", {32'b0, Result1}, 64'hFFFF_FFFF);
      chk("div0_r2", {32'b0, Result2}, 64'h1234);
      go_idle(1);

      // Reset pulsed while the iteration count is 10.
      @(posedge CLK);
      #1;
      MCycleOp = 1'b0;
      Operand1 = 32'd123;
      Operand2 = 32'd456;
      Start    = 1'b1;
      repeat (11) @(posedge CLK);
      #1;
      RESET = 1'b1;
      Start = 1'b0;
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("midreset_busy", {63'b0, Busy}, 64'd0);
      chk("midreset_r1", {32'b0, Result1}, 64'd0);
      chk("midreset_r2", {32'b0, Result2}, 64'd0);
      do_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b0);
      chk("mul3x5_r1", {32'b0, Result1}, 64'hF);
      chk("mul3x5_r2", {32'b0, Result2}, 64'h0);

`ifdef MCYCLE_SIGNED_EN
      do_op(1'b0, 32'hFFFF_FFF9, 32'd3, 1'b1, 1'b0);
      chk("smul_r1", {32'b0, Result1}, 64'hFFFF_FFEB);
      chk("smul_r2", {32'b0, Result2}, 64'hFFFF_FFFF);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      chk("sdiv_r1", {32'b0, Result1}, 64'hFFFF_FFFD);
      chk("sdiv_r2", {32'b0, Result2}, 64'hFFFF_FFFF);
`endif

      // Randomized ops with random gaps (0 = back-to-back) and mid-op input noise.
      for (int t = 0; t < 30; t++) begin
         gap = $urandom_range(0, 3);
         if (gap > 0) go_idle(gap - 1);
         r_op_t = 1'($urandom);
         ra     = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
`ifdef MCYCLE_SIGNED_EN
         r_s_t = 1'($urandom);
`else
         r_s_t = 1'b0;
`endif
         do_op(r_op_t, ra, rb, r_s_t, 1'($urandom));
      end

      go_idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
